axil_ram_responder: RTL and testbench
=====================================

// Module: axil_ram_responder
// PURPOSE
// - AXI4-Lite responder (slave) memory: the far end of the CPU's instruction_memory_axi / memory_axi initiators.
// - Word-addressed synchronous RAM behind independent read and write channel FSMs.
// - One outstanding transaction per channel; byte-strobed writes; registered responses.
// - Serves simulation/FPGA builds as IMEM/DMEM backing store until external memory is attached.
// PARAMETERS
// - ADDR_WIDTH  32    byte-address width of AWADDR/ARADDR
// - DATA_WIDTH  32    data width (XLEN); STRB width = DATA_WIDTH/8
// - MEM_WORDS   1024  RAM depth in DATA_WIDTH words (power of two)
// - BASE_ADDR   0     byte address of word 0
// PORTS
// - i_Clock       in   1     clock, all logic on posedge
// - i_Reset_N     in   1     synchronous active-low reset
// - i_Awaddr      in   ADDR  write address
// - i_Awvalid     in   1     write address valid
// - o_Awready     out  1     write address ready
// - i_Wdata       in   DATA  write data
// - i_Wstrb       in   DATA/8 byte-lane write enables
// - i_Wvalid      in   1     write data valid
// - o_Wready      out  1     write data ready
// - o_Bresp       out  2     write response (00 OKAY, 10 SLVERR)
// - o_Bvalid      out  1     write response valid
// - i_Bready      in   1     write response ready
// - i_Araddr      in   ADDR  read address
// - i_Arvalid     in   1     read address valid
// - o_Arready     out  1     read address ready
// - o_Rdata       out  DATA  read data
// - o_Rresp       out  2     read response
// - o_Rvalid      out  1     read data valid
// - i_Rready      in   1     read data ready
// BEHAVIOUR
// - Clock i_Clock; reset i_Reset_N synchronous, active-low: sampled 0 at posedge -> reset.
// - Reset: Bvalid=Rvalid=0, Bresp=Rresp=00, Rdata=0, AW/W latches empty; readies 0 while i_Reset_N=0; RAM contents retained.
// - Reset mid-transaction aborts it: pending B/R dropped, half-captured AW/W discarded, no RAM write.
// - Word index = (addr-BASE_ADDR)>>log2(DATA_WIDTH/8); addr low bits ignored (no misalignment check).
// - Write FSM: W_IDLE -> W_HAVE_ADDR (AW only) / W_HAVE_DATA (W only) -> W_RESP; AW+W same cycle: W_IDLE -> W_RESP.
// - o_Awready = !aw_held && !Bvalid; o_Wready = !w_held && !Bvalid (combinational from state, gated by reset).
// - Commit at the edge ending the cycle of the later AW/W handshake: bytes with Wstrb[i]=1 written, others kept; Bvalid=1 from next cycle.
// - Wstrb=0 is legal: no RAM change, OKAY response.
// - Bvalid/Bresp held stable until Bvalid&&Bready; then W_IDLE, readies reassert next cycle (no back-to-back overlap).
// - Read FSM: R_IDLE -> R_RESP on Arvalid&&Arready; Rdata/Rvalid registered, latency 1 cycle.
// - o_Arready = !Rvalid; Rdata/Rresp held stable until Rvalid&&Rready, then R_IDLE.
// - Read accept and write commit to same word in same cycle: read returns pre-write data.
// - Channels independent; read never waits on write and vice versa.
// - Valid from initiator is never required to wait on ready; responder never drops Bvalid/Rvalid without handshake.
// CONFIGURATION
// - AXIL_RAM_RANGE_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*DATA_WIDTH/8) -> no RAM write,
//   Bresp=10 (SLVERR); read returns Rdata=0, Rresp=10. Timing unchanged.
// - Not defined: index = low log2(MEM_WORDS) bits of word index (aliasing wrap), responses always 00 (OKAY).
// TESTING
// - Reset: hold i_Reset_N=0 3 cycles with Awvalid=Arvalid=1 -> all readies/valids 0; release -> Awready=Wready=Arready=1 next cycle.
// - AW 0x10 cycle N, W 0xDEADBEEF strb 1111 cycle N+3 -> Bvalid at N+4, Bresp=00; read 0x10 -> Rvalid 1 cycle after AR, Rdata=0xDEADBEEF.
// - Word 0x10 = 0xDEADBEEF, write 0x000000AA strb 0001 (AW+W same cycle) -> read 0xDEADBEAA.
// - Bready=0 for 5 cycles -> Bvalid/Bresp stable, Awready=Wready=0; Rready=0 likewise keeps Rdata stable, Arready=0.
// - Same cycle: write 0x20<-0x11111111 commits and AR 0x20 accepted (old 0x0) -> Rdata=0x0; next read -> 0x11111111.
// - RANGE_CHECK_EN, MEM_WORDS=1024: write/read 0x1000 -> Bresp=10, Rresp=10, Rdata=0, word 0 unchanged; without macro -> aliases word 0.

Source files
------------

// File: rtl/axil_ram_responder.sv
// AXI4-Lite RAM responder: word-addressed synchronous RAM behind independent read/write channel FSMs.
// Optional macro AXIL_RAM_RANGE_CHECK_EN: out-of-window accesses answer SLVERR instead of aliasing.
module axil_ram_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_N,
    input  logic [ADDR_WIDTH-1:0]   i_Awaddr,
    input  logic                    i_Awvalid,
    output logic                    o_Awready,
    input  logic [DATA_WIDTH-1:0]   i_Wdata,
    input  logic [DATA_WIDTH/8-1:0] i_Wstrb,
    input  logic                    i_Wvalid,
    output logic                    o_Wready,
    output logic [1:0]              o_Bresp,
    output logic                    o_Bvalid,
    input  logic                    i_Bready,
    input  logic [ADDR_WIDTH-1:0]   i_Araddr,
    input  logic                    i_Arvalid,
    output logic                    o_Arready,
    output logic [DATA_WIDTH-1:0]   o_Rdata,
    output logic [1:0]              o_Rresp,
    output logic                    o_Rvalid,
    input  logic                    i_Rready
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = $clog2(MEM_WORDS);
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'b00,
        W_HAVE_ADDR = 2'b01,
        W_HAVE_DATA = 2'b10,
        W_RESP      = 2'b11
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    function automatic logic [IDX_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset[BYTE_SHIFT +: IDX_WIDTH];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state_r, w_state_next_s;
    r_state_t              r_state_r, r_state_next_s;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [STRB_WIDTH-1:0] w_strb_r;
    logic                  bvalid_r, rvalid_r;
    logic [1:0]            bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  aw_hs_s, w_hs_s, ar_hs_s;
    logic                  commit_s, mem_we_s, wr_ok_s, rd_ok_s;
    logic [ADDR_WIDTH-1:0] commit_addr_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic [STRB_WIDTH-1:0] commit_strb_s;
    logic [IDX_WIDTH-1:0]  commit_idx_s, rd_idx_s;

`ifdef AXIL_RAM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * STRB_WIDTH);

    function automatic logic addr_in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    endfunction

    assign wr_ok_s = addr_in_window(commit_addr_s);
    assign rd_ok_s = addr_in_window(i_Araddr);
`else
    assign wr_ok_s = 1'b1;
    assign rd_ok_s = 1'b1;
`endif

    // Readies decode from state only; a held response blocks new requests on its channel.
    assign o_Awready = i_Reset_N && (w_state_r != W_HAVE_ADDR) && !bvalid_r;
    assign o_Wready  = i_Reset_N && (w_state_r != W_HAVE_DATA) && !bvalid_r;
    assign o_Arready = i_Reset_N && !rvalid_r;

    assign aw_hs_s = i_Awvalid && o_Awready;
    assign w_hs_s  = i_Wvalid && o_Wready;
    assign ar_hs_s = i_Arvalid && o_Arready;

    assign commit_idx_s = word_index(commit_addr_s);
    assign rd_idx_s     = word_index(i_Araddr);
    assign mem_we_s     = commit_s && wr_ok_s;

    // Write channel next state; commit operands come from the latch or the live bus.
    always_comb begin
        w_state_next_s = w_state_r;
        commit_s       = 1'b0;
        commit_addr_s  = i_Awaddr;
        commit_data_s  = i_Wdata;
        commit_strb_s  = i_Wstrb;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s       = 1'b1;
                    w_state_next_s = W_RESP;
                end else if (aw_hs_s) begin
                    w_state_next_s = W_HAVE_ADDR;
                end else if (w_hs_s) begin
                    w_state_next_s = W_HAVE_DATA;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_HAVE_ADDR: begin
                commit_addr_s = aw_addr_r;
                if (w_hs_s) begin
                    commit_s       = 1'b1;
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_HAVE_ADDR;
                end
            end
            W_HAVE_DATA: begin
                commit_data_s = w_data_r;
                commit_strb_s = w_strb_r;
                if (aw_hs_s) begin
                    commit_s       = 1'b1;
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_HAVE_DATA;
                end
            end
            W_RESP: begin
                if (i_Bready) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_RESP;
                end
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Read channel next state.
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_next_s = R_RESP;
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
            R_RESP: begin
                if (i_Rready) begin
                    r_state_next_s = R_IDLE;
                end else begin
                    r_state_next_s = R_RESP;
                end
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Write channel state, operand latches and registered B response.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            w_state_r <= W_IDLE;
            aw_addr_r <= {ADDR_WIDTH{1'b0}};
            w_data_r  <= {DATA_WIDTH{1'b0}};
            w_strb_r  <= {STRB_WIDTH{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_next_s;
            bvalid_r  <= (w_state_next_s == W_RESP);
            if (aw_hs_s) begin
                aw_addr_r <= i_Awaddr;
            end
            if (w_hs_s) begin
                w_data_r <= i_Wdata;
                w_strb_r <= i_Wstrb;
            end
            if (commit_s) begin
                bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read channel state and registered R response; RAM read sees pre-write contents.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_next_s;
            rvalid_r  <= (r_state_next_s == R_RESP);
            if (ar_hs_s) begin
                rdata_r <= rd_ok_s ? mem[rd_idx_s] : {DATA_WIDTH{1'b0}};
                rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset.
    always_ff @(posedge i_Clock) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (commit_strb_s[b]) begin
                    mem[commit_idx_s][8*b +: 8] <= commit_data_s[8*b +: 8];
                end
            end
        end
    end

    assign o_Bvalid = bvalid_r;
    assign o_Bresp  = bresp_r;
    assign o_Rvalid = rvalid_r;
    assign o_Rresp  = rresp_r;
    assign o_Rdata  = rdata_r;
endmodule

// File: tb/tb_axil_ram_responder.sv
// Directed bench for axil_ram_responder: vector table plus hand sequences for stalls, overlap and reset.
module tb_axil_ram_responder;
    logic        clk, rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;

    axil_ram_responder dut (
        .i_Clock(clk), .i_Reset_N(rst_n),
        .i_Awaddr(awaddr), .i_Awvalid(awvalid), .o_Awready(awready),
        .i_Wdata(wdata), .i_Wstrb(wstrb), .i_Wvalid(wvalid), .o_Wready(wready),
        .o_Bresp(bresp), .o_Bvalid(bvalid), .i_Bready(bready),
        .i_Araddr(araddr), .i_Arvalid(arvalid), .o_Arready(arready),
        .o_Rdata(rdata), .o_Rresp(rresp), .o_Rvalid(rvalid), .i_Rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp, output int bwait);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            awaddr  = a; wdata = d; wstrb = s;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            #1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        bwait = 0;
        #1;
        while (!bvalid && bwait < 20) begin
            @(negedge clk); #1; bwait++;
        end
        resp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int rwait);
        bit fired;
        int cyc;
        fired = 1'b0; cyc = 0;
        while (!fired && cyc < 20) begin
            @(negedge clk);
            araddr = a; arvalid = 1'b1;
            #1;
            fired = arready;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        rwait = 0;
        #1;
        while (!rvalid && rwait < 20) begin
            @(negedge clk); #1; rwait++;
        end
        d = rdata; resp = rresp;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          w;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 3, 32'h0, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 0, 0, 32'h0, 2'b00};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEAA, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 3, 0, 32'h0, 2'b00};
        vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 1, 1, 32'h0, 2'b00};
        vecs[7]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00};
        vecs[8]  = '{1'b1, 32'h0000_0016, 32'hAABB_CCDD, 4'hA, 0, 0, 32'h0, 2'b00};
        vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 32'hAA34_CC78, 2'b00};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2, 2, 32'h0, 2'b00};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 32'hCAFE_F00D, 2'b00};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 0, 1, 32'h0, 2'b00};
        vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 0, 32'h0BAD_C0DE, 2'b00};
        vecs[14] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 0, 0, 32'h0, 2'b00};
        vecs[15] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 32'h0000_0000, 2'b00};

        rst_n = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b1; rready = 1'b0;

        // Reset held three cycles with requests pending.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset%0d rdy/valid", k), {27'h0, awready, wready, arready, bvalid, rvalid}, 32'h0);
        end
        check("reset rdata", rdata, 32'h0);
        check("reset bresp/rresp", {28'h0, bresp, rresp}, 32'h0);
        rst_n = 1'b1; awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post-reset readies", {29'h0, awready, wready, arready}, 32'h7);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, r, w);
                check($sformatf("vec%0d bresp", i), {30'h0, r}, {30'h0, vecs[i].exp_resp});
                check($sformatf("vec%0d b latency", i), w, 32'd0);
            end else begin
                axi_read(vecs[i].addr, d, r, w);
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d rresp", i), {30'h0, r}, {30'h0, vecs[i].exp_resp});
                check($sformatf("vec%0d r latency", i), w, 32'd0);
            end
        end

        // B backpressure: response and readies frozen while Bready is low.
        @(negedge clk);
        awaddr = 32'h30; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bstall%0d", k), {28'h0, bvalid, bresp, awready | wready}, 32'h8);
            @(negedge clk);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        #1;
        check("bstall release", {29'h0, bvalid, awready, wready}, 32'h3);

        // R backpressure with a competing AR presented during the stall.
        @(negedge clk);
        araddr = 32'h30; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        araddr = 32'h10;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rstall%0d data", k), rdata, 32'h55AA_55AA);
            check($sformatf("rstall%0d flags", k), {30'h0, rvalid, arready}, 32'h2);
            @(negedge clk);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        #1;
        check("rstall release", {31'h0, rvalid}, 32'h0);

        // Read accepted in the same cycle the write to that word commits.
        @(negedge clk);
        awaddr = 32'h20; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h20; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #1;
        check("overlap rdata", rdata, 32'h0);
        check("overlap valids", {30'h0, rvalid, bvalid}, 32'h3);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h20, d, r, w);
        check("overlap reread", d, 32'h1111_1111);

        // Reset mid-transaction: half-captured AW and pending R are dropped.
        @(negedge clk);
        awaddr = 32'h0; awvalid = 1'b1; araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset state", {27'h0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
        axi_write(32'h24, 32'h9999_9999, 4'hF, 1, 0, r, w);
        check("midreset wresp", {30'h0, r}, 32'h0);
        axi_read(32'h0, d, r, w);
        check("midreset word0", d, 32'hCAFE_F00D);
        axi_read(32'h24, d, r, w);
        check("midreset word9", d, 32'h9999_9999);

        // One past the window: SLVERR with range check, alias of word 0 otherwise.
        axi_write(32'h1000, 32'h7777_7777, 4'hF, 0, 0, r, w);
`ifdef AXIL_RAM_RANGE_CHECK_EN
        check("oob bresp", {30'h0, r}, 32'h2);
        axi_read(32'h1000, d, r, w);
        check("oob rdata", d, 32'h0);
        check("oob rresp", {30'h0, r}, 32'h2);
        axi_read(32'h0, d, r, w);
        check("oob word0", d, 32'hCAFE_F00D);
`else
        check("alias bresp", {30'h0, r}, 32'h0);
        axi_read(32'h1000, d, r, w);
        check("alias rdata", d, 32'h7777_7777);
        check("alias rresp", {30'h0, r}, 32'h0);
        axi_read(32'h0, d, r, w);
        check("alias word0", d, 32'h7777_7777);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
